// File: rtl/imem_dmem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and data access.
// One transaction in flight; data has priority, bounded by a streak limit so fetch is never starved.
module imem_dmem_arbiter #(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          flush_if,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic [3:0]    d_be,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_IF, WAIT_D} state_t;

   localparam int SW = $clog2(MAX_DATA_STREAK + 1);

   state_t        state_q;
   logic [SW-1:0] streak_q;
   logic          owner_if_q;
   logic          kill_q;
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [3:0]    mem_be_q;
   logic          if_rvalid_q;
   logic [DW-1:0] if_rdata_q;
   logic          d_rvalid_q;
   logic [DW-1:0] d_rdata_q;

   logic if_live;
   logic streak_full;
   logic grant_d;
   logic grant_if;

   // A fetch being flushed this cycle does not compete; the data side may take the slot.
   assign if_live     = if_req && !flush_if;
   assign streak_full = (streak_q == SW'(MAX_DATA_STREAK));
   assign grant_d     = (state_q == IDLE) && d_req && !(if_live && streak_full);
   assign grant_if    = (state_q == IDLE) && if_live && !grant_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         owner_if_q  <= 1'b0;
         kill_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= 4'h0;
         if_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         d_rvalid_q  <= 1'b0;
         d_rdata_q   <= '0;
      end else begin
         mem_req_q   <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               kill_q <= 1'b0;
               if (grant_d) begin
                  state_q     <= ISSUE;
                  owner_if_q  <= 1'b0;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_we;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
                  mem_be_q    <= d_be;
                  // The streak only counts data grants that actually held off a fetch.
                  if (!if_req)
                     streak_q <= '0;
                  else if (!streak_full)
                     streak_q <= streak_q + 1'b1;
               end else if (grant_if) begin
                  state_q     <= ISSUE;
                  owner_if_q  <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= if_addr;
                  mem_wdata_q <= '0;
                  mem_be_q    <= 4'hF;
                  streak_q    <= '0;
               end
            end
            ISSUE: begin
               state_q <= owner_if_q ? WAIT_IF : WAIT_D;
               if (owner_if_q && flush_if)
                  kill_q <= 1'b1;
            end
            WAIT_IF: begin
               if (mem_rvalid) begin
                  state_q <= IDLE;
                  kill_q  <= 1'b0;
                  if (!kill_q && !flush_if) begin
                     if_rvalid_q <= 1'b1;
                     if_rdata_q  <= mem_rdata;
                  end
               end else if (flush_if) begin
                  kill_q <= 1'b1;
               end
            end
            WAIT_D: begin
               if (mem_rvalid) begin
                  state_q    <= IDLE;
                  d_rvalid_q <= 1'b1;
                  if (!mem_we_q)
                     d_rdata_q <= mem_rdata;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_gnt    = grant_if;
   assign d_gnt     = grant_d;
   assign if_rvalid = if_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: a behavioural memory answers mem_req after mem_lat cycles.
// Inputs are driven 2 time units after the rising edge and outputs sampled 1 unit later.
module tb_imem_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        flush_if = 1'b0;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [3:0]  d_be = 4'h0;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_model [0:255];
   int          mem_lat  = 2;
   bit          mem_auto = 1'b1;
   logic [31:0] r_addr, r_wdata;
   logic        r_we;
   logic [3:0]  r_be;

   imem_dmem_arbiter #(.AW(32), .DW(32), .MAX_DATA_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   // Memory responder: command seen in cycle N is answered during cycle N+mem_lat.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (mem_auto && mem_req === 1'b1) begin
            r_addr  = mem_addr;
            r_we    = mem_we;
            r_wdata = mem_wdata;
            r_be    = mem_be;
            repeat (mem_lat) @(posedge clk);
            #1;
            if (r_we) begin
               for (int b = 0; b < 4; b++)
                  if (r_be[b]) mem_model[r_addr[9:2]][8*b +: 8] = r_wdata[8*b +: 8];
               mem_rdata = 32'hBADC0DE5;
            end else begin
               mem_rdata = mem_model[r_addr[9:2]];
            end
            mem_rvalid = 1'b1;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_cmd: req=%b we=%b be=%h expected 0 0 0", mem_req, mem_we, mem_be); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
      checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: if=%b d=%b expected 0 0", if_rvalid, d_rvalid); end
      checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: if=%h d=%h expected 0 0", if_rdata, d_rdata); end
      checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: if=%b d=%b expected 0 0", if_gnt, d_gnt); end
      step();
      rst = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_fetch_only();
      mem_lat = 2;
      step(); if_req = 1'b1; if_addr = 32'h10; #1;
      checks++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL t1_gnt: if=%b d=%b expected 1 0", if_gnt, d_gnt); end
      step(); if_req = 1'b0; #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL t1_mem_req: req=%b addr=%h expected 1 00000010", mem_req, mem_addr); end
      checks++; if (mem_we !== 1'b0 || mem_be !== 4'hF || busy !== 1'b1) begin errors++; $display("FAIL t1_mem_cmd: we=%b be=%h busy=%b expected 0 f 1", mem_we, mem_be, busy); end
      step(); #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t1_req_pulse: got %b expected 0", mem_req); end
      step(); #1;
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL t1_early_rvalid: got %b expected 0", if_rvalid); end
      step(); #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093) begin errors++; $display("FAIL t1_rvalid: rvalid=%b data=%h expected 1 00500093", if_rvalid, if_rdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_done: got %b expected 0", busy); end
      step(); #1;
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL t1_rvalid_pulse: got %b expected 0", if_rvalid); end
      $display("test_fetch_only done: if_rdata=%h", if_rdata);
   endtask

   task automatic test_store();
      mem_lat = 1;
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL t3_load_gnt: got %b expected 1", d_gnt); end
      step(); d_req = 1'b0;
      step();
      step(); #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344) begin errors++; $display("FAIL t3_load: rvalid=%b data=%h expected 1 11223344", d_rvalid, d_rdata); end
      step(); d_req = 1'b1; d_we = 1'b1; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL t3_store_gnt: got %b expected 1", d_gnt); end
      step(); d_req = 1'b0; d_we = 1'b0; #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011) begin errors++; $display("FAIL t3_store_cmd: req=%b we=%b be=%b expected 1 1 0011", mem_req, mem_we, mem_be); end
      checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t3_store_bus: addr=%h wdata=%h expected 00000100 deadbeef", mem_addr, mem_wdata); end
      step();
      step(); #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11223344) begin errors++; $display("FAIL t3_store_done: rvalid=%b data=%h expected 1 11223344", d_rvalid, d_rdata); end
      step(); d_req = 1'b1; #1;
      step(); d_req = 1'b0;
      step();
      step(); #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1122BEEF) begin errors++; $display("FAIL t3_reload: rvalid=%b data=%h expected 1 1122beef", d_rvalid, d_rdata); end
      $display("test_store done: d_rdata=%h", d_rdata);
   endtask

   task automatic test_contention();
      bit exp_if [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      bit seq [10];
      int n = 0;
      int run = 0;
      int max_run = 0;
      mem_lat = 1;
      step(); if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
      for (int c = 0; c < 80 && n < 10; c++) begin
         #1;
         checks++; if (if_gnt === 1'b1 && d_gnt === 1'b1) begin errors++; $display("FAIL t2_dual_gnt: if=%b d=%b expected one-hot", if_gnt, d_gnt); end
         if (d_gnt === 1'b1) begin seq[n] = 1'b0; n++; run++; if (run > max_run) max_run = run; end
         else if (if_gnt === 1'b1) begin seq[n] = 1'b1; n++; run = 0; end
         if (n < 10) step();
      end
      step(); if_req = 1'b0; d_req = 1'b0;
      checks++; if (n != 10) begin errors++; $display("FAIL t2_grant_count: got %0d expected 10", n); end
      for (int i = 0; i < n; i++) begin
         checks++; if (seq[i] !== exp_if[i]) begin errors++; $display("FAIL t2_order[%0d]: got %s expected %s", i, seq[i] ? "IF" : "D", exp_if[i] ? "IF" : "D"); end
      end
      checks++; if (max_run > 4) begin errors++; $display("FAIL t2_streak: got %0d consecutive D grants expected <=4", max_run); end
      for (int c = 0; c < 20 && busy === 1'b1; c++) step();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_drain: busy=%b expected 0", busy); end
      $display("test_contention done: %0d grants, longest D run %0d", n, max_run);
   endtask

   task automatic test_flush();
      mem_lat = 3;
      step(); if_req = 1'b1; if_addr = 32'h20; #1;
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL t4_gnt: got %b expected 1", if_gnt); end
      step(); if_req = 1'b0;
      step(); flush_if = 1'b1; #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_wait: got %b expected 1", busy); end
      step(); flush_if = 1'b0; #1;
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL t4_rvalid_c3: got %b expected 0", if_rvalid); end
      step(); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_resp: got %b expected 1", busy); end
      step(); #1;
      checks++; if (if_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_killed: rvalid=%b busy=%b expected 0 0", if_rvalid, busy); end
      checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("FAIL t4_rdata_hold: got %h expected 00500093", if_rdata); end
      step(); #1;
      checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL t4_rvalid_c6: got %b expected 0", if_rvalid); end
      mem_lat = 2;
      step(); if_req = 1'b1; if_addr = 32'h24; #1;
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL t4_next_gnt: got %b expected 1", if_gnt); end
      step(); if_req = 1'b0;
      step();
      step();
      step(); #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00A00113) begin errors++; $display("FAIL t4_next_fetch: rvalid=%b data=%h expected 1 00a00113", if_rvalid, if_rdata); end
      $display("test_flush done: if_rdata=%h", if_rdata);
   endtask

   task automatic test_flush_idle();
      mem_lat = 2;
      step(); if_req = 1'b1; if_addr = 32'h28; flush_if = 1'b1; #1;
      checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL t6_suppress: if=%b d=%b expected 0 0", if_gnt, d_gnt); end
      step(); flush_if = 1'b0; #1;
      checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL t6_gnt_next: got %b expected 1", if_gnt); end
      step(); if_req = 1'b0;
      step();
      step();
      step(); #1;
      checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00B00193) begin errors++; $display("FAIL t6_fetch: rvalid=%b data=%h expected 1 00b00193", if_rvalid, if_rdata); end
      $display("test_flush_idle done: if_rdata=%h", if_rdata);
   endtask

   task automatic test_reset_midop();
      mem_auto = 1'b0;
      step(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL t5_gnt: got %b expected 1", d_gnt); end
      step(); d_req = 1'b0; #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t5_mem_req: got %b expected 1", mem_req); end
      step(); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_wait_d: busy=%b expected 1", busy); end
      #1; rst = 1'b0; #1;
      checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL t5_async_reset: busy=%b req=%b addr=%h expected 0 0 0", busy, mem_req, mem_addr); end
      checks++; if (d_rdata !== 32'h0 || if_rdata !== 32'h0) begin errors++; $display("FAIL t5_rdata_reset: d=%h if=%h expected 0 0", d_rdata, if_rdata); end
      step(); rst = 1'b1;
      step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step(); mem_rvalid = 1'b0; #1;
      checks++; if (d_rvalid !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h0) begin errors++; $display("FAIL t5_late_rvalid: rvalid=%b busy=%b data=%h expected 0 0 0", d_rvalid, busy, d_rdata); end
      step(); #1;
      checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL t5_quiet: d=%b if=%b expected 0 0", d_rvalid, if_rvalid); end
      mem_auto = 1'b1;
      $display("test_reset_midop done");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[8'h04] = 32'h00500093;
      mem_model[8'h08] = 32'h12345678;
      mem_model[8'h09] = 32'h00A00113;
      mem_model[8'h0A] = 32'h00B00193;
      mem_model[8'h40] = 32'h11223344;
      test_reset();
      test_fetch_only();
      test_store();
      test_contention();
      test_flush();
      test_flush_idle();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
